// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM sequencing fetch/decode/execute/memory/writeback for the multicycle MIPS datapath
module multicycle_controller #(
    parameter int CNT_W           = 16,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             ZeroFlag,
    output logic             initPC,
    output logic             PCLoad,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             regWriteSignal,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUop,
    output logic [1:0]       PCSrc,
    output logic             halted,
    output logic [CNT_W-1:0] InstrCount
);
    typedef enum logic [3:0] {
        S_INIT, S_IF, S_ID, S_REX, S_RWB, S_MEMADR, S_MEMRD, S_MEMWB,
        S_MEMWR, S_BR, S_JMP, S_IEX, S_IWB, S_ILLEGAL, S_HALT
    } state_t;
    typedef struct packed {
        logic       init_pc;
        logic       pc_load;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       halted;
    } ctl_t;
    state_t state, nxt;
    ctl_t ctl;
    logic [2:0] r_op, i_op;
    logic r_ok, retire;
    // Control word for a state; unlisted fields stay 0
    function automatic ctl_t decode(input state_t s, input logic [2:0] rop, input logic [2:0] iop);
        ctl_t d;
        d = '0;
        case (s)
            S_INIT: d.init_pc = 1'b1;
            S_IF: begin
                d.pc_load   = 1'b1;
                d.mem_read  = 1'b1;
                d.ir_write  = 1'b1;
                d.alu_src_b = 2'b01;
                d.alu_op    = 3'b010;
            end
            S_ID: begin
                d.alu_src_b = 2'b11;
                d.alu_op    = 3'b010;
            end
            S_REX: begin
                d.alu_src_a = 1'b1;
                d.alu_op    = rop;
            end
            S_RWB: begin
                d.reg_dst   = 1'b1;
                d.reg_write = 1'b1;
            end
            S_MEMADR: begin
                d.alu_src_a = 1'b1;
                d.alu_src_b = 2'b10;
                d.alu_op    = 3'b010;
            end
            S_MEMRD: begin
                d.iord     = 1'b1;
                d.mem_read = 1'b1;
            end
            S_MEMWB: begin
                d.mem_to_reg = 1'b1;
                d.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                d.iord      = 1'b1;
                d.mem_write = 1'b1;
            end
            S_BR: begin
                d.alu_src_a = 1'b1;
                d.alu_op    = 3'b110;
                d.pc_src    = 2'b01;
            end
            S_JMP: begin
                d.pc_src  = 2'b10;
                d.pc_load = 1'b1;
            end
            S_IEX: begin
                d.alu_src_a = 1'b1;
                d.alu_src_b = 2'b10;
                d.alu_op    = iop;
            end
            S_IWB: d.reg_write = 1'b1;
            S_HALT: d.halted = 1'b1;
            default: ;
        endcase
        return d;
    endfunction
    // R-type funct decode into a direct ALU code plus legality
    always_comb begin
        r_op = 3'b010;
        r_ok = 1'b1;
        case (func)
            6'h20: r_op = 3'b010;
            6'h22: r_op = 3'b110;
            6'h24: r_op = 3'b000;
            6'h25: r_op = 3'b001;
            6'h2a: r_op = 3'b111;
            default: r_ok = 1'b0;
        endcase
    end
    assign i_op = opcode == 6'h0a ? 3'b111 : opcode == 6'h0c ? 3'b000 : 3'b010;
    assign retire = state inside {S_RWB, S_MEMWB, S_MEMWR, S_BR, S_JMP, S_IWB};
    // Next-state selection; opcode is taken from the live IR, which only changes in IF
    always_comb begin
        nxt = S_IF;
        case (state)
            S_INIT: nxt = S_IF;
            S_IF: nxt = S_ID;
            S_ID: begin
                case (opcode)
                    6'h00: nxt = S_REX;
                    6'h23, 6'h2b: nxt = S_MEMADR;
                    6'h04, 6'h05: nxt = S_BR;
                    6'h02: nxt = S_JMP;
                    6'h08, 6'h0a, 6'h0c: nxt = S_IEX;
                    default: nxt = S_ILLEGAL;
                endcase
            end
            S_REX: nxt = r_ok ? S_RWB : S_ILLEGAL;
            S_MEMADR: nxt = opcode == 6'h23 ? S_MEMRD : S_MEMWR;
            S_MEMRD: nxt = S_MEMWB;
            S_IEX: nxt = S_IWB;
            S_ILLEGAL: nxt = HALT_ON_ILLEGAL ? S_HALT : S_IF;
            S_HALT: nxt = S_HALT;
            default: nxt = S_IF;
        endcase
    end
    // State, registered control word for the state being entered, and retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_INIT;
            ctl        <= decode(S_INIT, 3'b000, 3'b000);
            InstrCount <= '0;
        end else begin
            state      <= nxt;
            ctl        <= decode(nxt, r_op, i_op);
            InstrCount <= InstrCount + CNT_W'(retire);
        end
    end
    // Branch PC load is Mealy: beq loads on zero, bne (opcode bit 0 set) on non-zero
    assign PCLoad         = ctl.pc_load | (state == S_BR && (ZeroFlag ^ opcode[0]));
    assign initPC         = ctl.init_pc;
    assign IorD           = ctl.iord;
    assign MemRead        = ctl.mem_read;
    assign MemWrite       = ctl.mem_write;
    assign IRWrite        = ctl.ir_write;
    assign RegDst         = ctl.reg_dst;
    assign MemToReg       = ctl.mem_to_reg;
    assign regWriteSignal = ctl.reg_write;
    assign ALUSrcA        = ctl.alu_src_a;
    assign ALUSrcB        = ctl.alu_src_b;
    assign ALUop          = ctl.alu_op;
    assign PCSrc          = ctl.pc_src;
    assign halted         = ctl.halted;
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Moore/Mealy FSM that drives every control input of the multicycle MIPS datapath: memory, register file, ALU, operand muxes, PC and IR registers. The datapath reports opcode, funct and ZeroFlag back to this block. The block sequences fetch, decode, execute, memory and writeback for each instruction. It also counts retired instructions and halts on illegal encodings.

Parameters:
CNT_W, 16, width of retired-instruction counter (wraps modulo 2^CNT_W)
HALT_ON_ILLEGAL, 1, 1 = enter HALT on unknown opcode/funct; 0 = treat as NOP (return to IF)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
opcode  in  6  IR[31:26]
func  in  6  IR[5:0]
ZeroFlag  in  1  ALU zero flag (combinational, current cycle)
initPC  out  1  PC register clear
PCLoad  out  1  PC register ldin
IorD  out  1  memory address select: 0=PC, 1=ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register load
RegDst  out  1  write-register select: 0=rt, 1=rd
MemToReg  out  1  write-data select: 0=ALUOut, 1=MDR
regWriteSignal  out  1  register file write enable
ALUSrcA  out  1  0=PC, 1=A reg
ALUSrcB  out  2  00=B reg, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
ALUop  out  3  direct ALU code: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
PCSrc  out  2  00=ALU result, 01=ALUOut reg, 10=jump target {PC[31:28],imm26,00}
halted  out  1  high while in HALT
InstrCount  out  CNT_W  retired-instruction counter

Behaviour:
- rst is asynchronous: state <= INIT, InstrCount <= 0. While rst is high, outputs are the INIT decode.
- Outputs are decoded from state; unlisted outputs are 0 in every state. PCLoad in BR is Mealy (depends on ZeroFlag).
- INIT: initPC=1 -> IF.
- IF: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUop=010, PCSrc=00, PCLoad=1 -> ID.
- ID: ALUSrcA=0, ALUSrcB=11, ALUop=010 (branch target into ALUOut). Decode on opcode:
  - 000000 -> REX
  - 100011 (lw) or 101011 (sw) -> MEMADR
  - 000100 (beq) or 000101 (bne) -> BR
  - 000010 (j) -> JMP
  - 001000 (addi), 001010 (slti), 001100 (andi) -> IEX
  - other -> ILLEGAL
- REX: ALUSrcA=1, ALUSrcB=00, ALUop from func:
  - 100000 -> 010
  - 100010 -> 110
  - 100100 -> 000
  - 100101 -> 001
  - 101010 -> 111
  - Unknown func -> ILLEGAL (no write); otherwise -> RWB.
- RWB: RegDst=1, MemToReg=0, regWriteSignal=1 -> IF (retire).
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUop=010. lw -> MEMRD; sw -> MEMWR.
- MEMRD: MemRead=1, IorD=1 -> MEMWB.
- MEMWB: RegDst=0, MemToReg=1, regWriteSignal=1 -> IF (retire).
- MEMWR: MemWrite=1, IorD=1 -> IF (retire).
- BR: ALUSrcA=1, ALUSrcB=00, ALUop=110, PCSrc=01. PCLoad = ZeroFlag for beq, !ZeroFlag for bne -> IF (retire, taken or not).
- JMP: PCSrc=10, PCLoad=1 -> IF (retire).
- IEX: ALUSrcA=1, ALUSrcB=10. ALUop = 010 for addi, 111 for slti, 000 for andi -> IWB.
- IWB: RegDst=0, MemToReg=0, regWriteSignal=1 -> IF (retire).
- ILLEGAL: HALT_ON_ILLEGAL=1 -> HALT; HALT_ON_ILLEGAL=0 -> IF, no retire.
- HALT: halted=1, all strobes 0, stays in HALT until rst.
- The opcode used by MEMADR, IEX and BR is re-read from the live IR. IR is stable because IRWrite=1 only in IF.
- Retire: InstrCount increments by 1 on the clock edge leaving a retire state; wraps 2^CNT_W-1 -> 0.
- Latency from IF entry:
  - R-type / addi-class / sw: 4 cycles
  - lw: 5 cycles
  - beq / bne / j: 3 cycles
- MemRead and MemWrite are never high in the same cycle. regWriteSignal and MemWrite are never high in the same cycle.
- rst mid-instruction: immediate return to INIT, no partial write strobe after rst rises.

Test Plan:
- Release rst -> one cycle INIT with initPC=1, then IF with MemRead=IRWrite=PCLoad=1, ALUSrcB=01, ALUop=010; InstrCount=0.
- opcode=000000, func=100010 -> states IF,ID,REX(ALUop=110),RWB(RegDst=1, regWriteSignal=1); next IF at cycle 4; InstrCount=1.
- lw (100011) then sw (101011) -> lw takes 5 cycles with MEMRD IorD=1 MemRead=1 and MEMWB MemToReg=1; sw takes 4 cycles with MemWrite=1 exactly one cycle; InstrCount=2.
- beq with ZeroFlag=1 -> BR PCLoad=1, PCSrc=01. beq with ZeroFlag=0 -> PCLoad=0. bne inverts both cases. Each retires after 3 cycles.
- opcode=111111 with HALT_ON_ILLEGAL=1 -> ID, ILLEGAL, HALT, halted=1 held 20 cycles with all strobes 0, InstrCount unchanged. Repeat with HALT_ON_ILLEGAL=0 -> back to IF, InstrCount unchanged.
- Assert rst during MEMWR, asynchronously between edges -> MemWrite drops immediately, state INIT, InstrCount=0. Preload InstrCount path with 2^CNT_W retires -> InstrCount wraps to 0.
